// File: rtl/spdif_pkg.sv
// Shared encodings and reset defaults for the S/PDIF acquisition and lock controller.
package spdif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_VERIFY  = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_RESYNC  = 3'd4
  } state_e;

  localparam logic [1:0] SYNC_B   = 2'b00;
  localparam logic [1:0] SYNC_M   = 2'b01;
  localparam logic [1:0] SYNC_W   = 2'b10;
  localparam logic [1:0] SYNC_INV = 2'b11;

  localparam logic [7:0] THR_T1_DEF  = 8'd20;
  localparam logic [7:0] THR_T2_DEF  = 8'd38;
  localparam logic [7:0] THR_T3_DEF  = 8'd42;
  localparam logic [7:0] UI_MIN_INIT = 8'hFF;

endpackage

// File: rtl/spdif_ui_meter.sv
// Windowed minimum edge-interval tracker; yields the UI and the decoder
// classification thresholds on the cycle the window completes.
module spdif_ui_meter
  import spdif_pkg::*;
#(
  parameter int WIN_EDGES = 64,
  parameter int MIN_LEN   = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       start,
  input  logic       edge_valid,
  input  logic [7:0] edge_len,
  output logic       done,
  output logic [7:0] ui,
  output logic [7:0] t1,
  output logic [7:0] t2,
  output logic [7:0] t3
);

  localparam int CW = $clog2(WIN_EDGES + 1);

  logic [CW-1:0] cnt_q;
  logic [7:0]    min_q;
  logic          accept;
  logic [7:0]    min_nxt;
  logic [9:0]    ui10;

  function automatic logic [7:0] sat8(input logic [9:0] v);
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

  assign accept  = !start && edge_valid && (edge_len >= 8'(MIN_LEN));
  assign min_nxt = (edge_len < min_q) ? edge_len : min_q;
  // The completing edge is folded into the minimum combinationally.
  assign done    = accept && (cnt_q == CW'(WIN_EDGES - 1));
  assign ui      = min_nxt;
  assign ui10    = {2'b00, min_nxt};

  assign t1 = sat8(ui10 + (ui10 >> 1));
  assign t2 = sat8((ui10 << 1) + (ui10 >> 2));
  assign t3 = sat8((ui10 << 1) + (ui10 >> 1));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
      min_q <= UI_MIN_INIT;
    end else if (start || done) begin
      cnt_q <= '0;
      min_q <= UI_MIN_INIT;
    end else if (accept) begin
      cnt_q <= cnt_q + CW'(1);
      min_q <= min_nxt;
    end
  end

endmodule

// File: rtl/spdif_lock_ctrl.sv
// S/PDIF acquisition and lock controller: measures the UI, programs decoder
// thresholds and qualifies lock from preamble alternation and timing.
module spdif_lock_ctrl
  import spdif_pkg::*;
#(
  parameter int WIN_EDGES    = 64,
  parameter int MIN_LEN      = 4,
  parameter int VERIFY_SYNCS = 8,
  parameter int SYNC_TO      = 2048,
  parameter int ERR_MAX      = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       enable,
  input  logic       edge_valid,
  input  logic [7:0] edge_len,
  input  logic       sync_valid,
  input  logic [1:0] sync_type,
  output logic [7:0] thr_t1,
  output logic [7:0] thr_t2,
  output logic [7:0] thr_t3,
  output logic [7:0] ui_len,
  output logic       audio_locked,
  output logic       mute,
  output logic       err_pulse,
  output logic [2:0] state
);

  localparam int GW = $clog2(VERIFY_SYNCS + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(VERIFY_SYNCS);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_MAX);
  localparam logic [11:0]   TO_LAST   = 12'(SYNC_TO - 1);

  state_e        state_q, state_d;
  logic [7:0]    ui_q, ui_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic          locked_q, locked_d, mute_q, mute_d, err_q, err_d;
  logic [GW-1:0] good_q, good_d;
  logic [EW-1:0] errc_q, errc_d;
  logic [11:0]   to_q, to_d;
  logic [1:0]    last_q, last_d;
  logic          have_q, have_d, lgood_q, lgood_d;

  logic       meas_start, meas_done;
  logic [7:0] meas_ui, meas_t1, meas_t2, meas_t3;
  logic       sync_is_w, sync_is_bm, sync_good, tracking, timeout, any_err;

  assign meas_start = !(enable && state_q == ST_MEASURE);

  spdif_ui_meter #(
    .WIN_EDGES(WIN_EDGES),
    .MIN_LEN  (MIN_LEN)
  ) u_meter (
    .clk       (clk),
    .resetb    (resetb),
    .start     (meas_start),
    .edge_valid(edge_valid),
    .edge_len  (edge_len),
    .done      (meas_done),
    .ui        (meas_ui),
    .t1        (meas_t1),
    .t2        (meas_t2),
    .t3        (meas_t3)
  );

  assign sync_is_w  = (sync_type == SYNC_W);
  assign sync_is_bm = (sync_type == SYNC_B) || (sync_type == SYNC_M);
  // With no reference (fresh VERIFY or after an invalid preamble) any valid type is accepted.
  assign sync_good  = sync_valid && (sync_is_w || sync_is_bm) &&
                      (!have_q || (last_q == SYNC_INV) ||
                       ((last_q == SYNC_W) ? sync_is_bm : sync_is_w));
  assign tracking   = (state_q == ST_VERIFY) || (state_q == ST_LOCKED);
  assign timeout    = tracking && !sync_valid && (to_q == TO_LAST);
  assign any_err    = tracking && ((sync_valid && !sync_good) || timeout);

  always_comb begin
    state_d  = state_q;
    ui_d     = ui_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    t3_d     = t3_q;
    locked_d = locked_q;
    mute_d   = mute_q;
    err_d    = 1'b0;
    good_d   = good_q;
    errc_d   = errc_q;
    last_d   = last_q;
    have_d   = have_q;
    lgood_d  = lgood_q;
    to_d     = '0;

    if (tracking) begin
      to_d = (sync_valid || timeout) ? 12'd0 : to_q + 12'd1;
      if (sync_valid) begin
        last_d  = sync_type;
        have_d  = 1'b1;
        lgood_d = sync_good;
      end
    end

    case (state_q)
      ST_IDLE: state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (meas_done && (meas_ui != UI_MIN_INIT)) begin
          state_d = ST_VERIFY;
          ui_d    = meas_ui;
          t1_d    = meas_t1;
          t2_d    = meas_t2;
          t3_d    = meas_t3;
          good_d  = '0;
          errc_d  = '0;
          have_d  = 1'b0;
          lgood_d = 1'b0;
        end
      end
      ST_VERIFY: begin
        if (any_err) begin
          err_d   = 1'b1;
          state_d = ST_MEASURE;
        end else if (sync_good) begin
          good_d = good_q + GW'(1);
          if (good_d == GOOD_LAST) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            errc_d   = '0;
            to_d     = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          err_d  = 1'b1;
          errc_d = errc_q + EW'(1);
          if (errc_d == ERR_LAST) begin
            state_d  = ST_RESYNC;
            locked_d = 1'b0;
            mute_d   = 1'b1;
          end
        end else if (sync_good) begin
          if (sync_type == SYNC_B) mute_d = 1'b0;
          if (sync_is_w && lgood_q) errc_d = '0;
        end
      end
      ST_RESYNC: state_d = ST_MEASURE;
      default:   state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      mute_d   = 1'b1;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      ui_q     <= '0;
      t1_q     <= THR_T1_DEF;
      t2_q     <= THR_T2_DEF;
      t3_q     <= THR_T3_DEF;
      locked_q <= 1'b0;
      mute_q   <= 1'b1;
      err_q    <= 1'b0;
      good_q   <= '0;
      errc_q   <= '0;
      to_q     <= '0;
      last_q   <= '0;
      have_q   <= 1'b0;
      lgood_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ui_q     <= ui_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      t3_q     <= t3_d;
      locked_q <= locked_d;
      mute_q   <= mute_d;
      err_q    <= err_d;
      good_q   <= good_d;
      errc_q   <= errc_d;
      to_q     <= to_d;
      last_q   <= last_d;
      have_q   <= have_d;
      lgood_q  <= lgood_d;
    end
  end

  assign thr_t1       = t1_q;
  assign thr_t2       = t2_q;
  assign thr_t3       = t3_q;
  assign ui_len       = ui_q;
  assign audio_locked = locked_q;
  assign mute         = mute_q;
  assign err_pulse    = err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_spdif_lock_ctrl.sv
// Self-checking bench for spdif_lock_ctrl with randomized edge/preamble stimulus
// and a behavioural model of measurement, alternation and error accounting.
module tb_spdif_lock_ctrl;

  localparam int WIN = 64, MINL = 4, STO = 2048, EMAX = 4;

  logic       clk, resetb, enable, edge_valid, sync_valid;
  logic [7:0] edge_len;
  logic [1:0] sync_type;
  logic [7:0] thr_t1, thr_t2, thr_t3, ui_len;
  logic       audio_locked, mute, err_pulse;
  logic [2:0] state;
  int total = 0;
  int bad   = 0;

  spdif_lock_ctrl dut (
    .clk(clk), .resetb(resetb), .enable(enable),
    .edge_valid(edge_valid), .edge_len(edge_len),
    .sync_valid(sync_valid), .sync_type(sync_type),
    .thr_t1(thr_t1), .thr_t2(thr_t2), .thr_t3(thr_t3), .ui_len(ui_len),
    .audio_locked(audio_locked), .mute(mute), .err_pulse(err_pulse), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction
  function automatic int mdl_t1(int u); return sat((u * 3) / 2); endfunction
  function automatic int mdl_t2(int u); return sat((u * 9) / 4); endfunction
  function automatic int mdl_t3(int u); return sat((u * 5) / 2); endfunction

  // Builds a window of edges (glitches interleaved), predicts the UI as the
  // minimum of the non-glitch lengths, and records the state before the last edge.
  task automatic measure_window(input int ui, input int glitch_pct,
                                output int exp_ui, output int st_before);
    int lens[$];
    int acc, mn, len;
    acc = 0;
    mn  = 255;
    while (acc < WIN) begin
      if ($urandom_range(0, 99) < glitch_pct) begin
        lens.push_back($urandom_range(0, MINL - 1));
      end else begin
        len = (acc == 0) ? ui : ui * $urandom_range(1, 3);
        if (len > 255) len = 255;
        lens.push_back(len);
        acc++;
        if (len < mn) mn = len;
      end
    end
    exp_ui    = mn;
    st_before = -1;
    foreach (lens[i]) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == lens.size() - 1) st_before = int'(state);
      edge_valid = 1'b1;
      edge_len   = 8'(lens[i]);
      tick();
      edge_valid = 1'b0;
    end
  endtask

  task automatic send_sync(input logic [1:0] t);
    repeat ($urandom_range(0, 2)) tick();
    sync_valid = 1'b1;
    sync_type  = t;
    tick();
    sync_valid = 1'b0;
  endtask

  task automatic send_lock_seq();
    logic [1:0] seq [8];
    seq = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    for (int i = 0; i < 8; i++) send_sync(seq[i]);
  endtask

  task automatic test_reset();
    resetb = 1'b0; enable = 1'b0; edge_valid = 1'b0; sync_valid = 1'b0;
    edge_len = '0; sync_type = '0;
    tick(); tick();
    total++;
    if ({state, thr_t1, thr_t2, thr_t3, ui_len, audio_locked, mute, err_pulse} !==
        {3'd0, 8'd20, 8'd38, 8'd42, 8'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got st=%0d t1=%0d t2=%0d t3=%0d ui=%0d lk=%b mu=%b ep=%b exp 0/20/38/42/0/0/1/0",
               state, thr_t1, thr_t2, thr_t3, ui_len, audio_locked, mute, err_pulse);
    end
    resetb = 1'b1;
    tick();
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL idle_disabled got=%0d exp=0", state); end
  endtask

  task automatic test_measure();
    int eu, sb;
    enable = 1'b1;
    tick();
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL enter_measure got=%0d exp=1", state); end
    measure_window(14, 0, eu, sb);
    total++;
    if (sb != 1) begin bad++; $display("FAIL meas14_before_last got=%0d exp=1", sb); end
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL meas14_state got=%0d exp=2", state); end
    total++;
    if ({ui_len, thr_t1, thr_t2, thr_t3} !== {8'(eu), 8'(mdl_t1(eu)), 8'(mdl_t2(eu)), 8'(mdl_t3(eu))}) begin
      bad++;
      $display("FAIL meas14_thr got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               ui_len, thr_t1, thr_t2, thr_t3, eu, mdl_t1(eu), mdl_t2(eu), mdl_t3(eu));
    end
  endtask

  task automatic test_verify_err();
    send_sync(2'd0);
    send_sync(2'd2);
    total++;
    if ({state, err_pulse} !== {3'd2, 1'b0}) begin
      bad++; $display("FAIL verify_bw got st=%0d ep=%b exp st=2 ep=0", state, err_pulse);
    end
    send_sync(2'd2);
    total++;
    if ({state, err_pulse, audio_locked} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL verify_ww got st=%0d ep=%b lk=%b exp st=1 ep=1 lk=0", state, err_pulse, audio_locked);
    end
    tick();
    total++;
    if (err_pulse !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b exp=0", err_pulse); end
  endtask

  task automatic test_glitch();
    int eu, sb;
    measure_window(14, 30, eu, sb);
    total++;
    if (sb != 1) begin bad++; $display("FAIL glitch_not_counted got=%0d exp=1", sb); end
    total++;
    if ({state, ui_len, thr_t1, thr_t2, thr_t3} !==
        {3'd2, 8'(eu), 8'(mdl_t1(eu)), 8'(mdl_t2(eu)), 8'(mdl_t3(eu))}) begin
      bad++;
      $display("FAIL glitch_ui got st=%0d ui=%0d t1=%0d t2=%0d t3=%0d exp st=2 ui=%0d", state, ui_len,
               thr_t1, thr_t2, thr_t3, eu);
    end
  endtask

  task automatic test_lock();
    logic [1:0] seq [8];
    seq = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    for (int i = 0; i < 8; i++) begin
      send_sync(seq[i]);
      if (i == 6) begin
        total++;
        if ({state, audio_locked} !== {3'd2, 1'b0}) begin
          bad++; $display("FAIL lock_7th got st=%0d lk=%b exp st=2 lk=0", state, audio_locked);
        end
      end
    end
    total++;
    if ({state, audio_locked, mute} !== {3'd3, 1'b1, 1'b1}) begin
      bad++; $display("FAIL lock_8th got st=%0d lk=%b mu=%b exp 3/1/1", state, audio_locked, mute);
    end
    repeat (5) tick();
    total++;
    if (mute !== 1'b1) begin bad++; $display("FAIL mute_held got=%b exp=1", mute); end
    send_sync(2'd0);
    total++;
    if ({mute, audio_locked} !== {1'b0, 1'b1}) begin
      bad++; $display("FAIL unmute_on_b got mu=%b lk=%b exp mu=0 lk=1", mute, audio_locked);
    end
  endtask

  task automatic test_random_locked();
    int prev, t, r, errs, exp_state;
    bit pgood, good, exp_mute;
    prev = 0; pgood = 1'b1; errs = 0; exp_mute = 1'b0; exp_state = 3;
    for (int n = 0; n < 80 && exp_state == 3; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65) t = (prev == 2) ? $urandom_range(0, 1) : 2;
      else        t = $urandom_range(0, 3);
      good = (t != 3) && (prev == 3 || ((prev == 2) != (t == 2)));
      if (!good) errs++;
      else if (t == 2 && pgood) errs = 0;
      if (good && t == 0) exp_mute = 1'b0;
      if (errs == EMAX) begin exp_state = 4; exp_mute = 1'b1; end
      prev  = t;
      pgood = good;
      send_sync(2'(t));
      total++;
      if ({state, err_pulse, mute, audio_locked} !==
          {3'(exp_state), !good, exp_mute, exp_state == 3}) begin
        bad++;
        $display("FAIL rand_locked n=%0d t=%0d got st=%0d ep=%b mu=%b lk=%b exp st=%0d ep=%b mu=%b",
                 n, t, state, err_pulse, mute, audio_locked, exp_state, !good, exp_mute);
      end
    end
    if (exp_state == 4) begin
      tick();
      total++;
      if (state !== 3'd1) begin bad++; $display("FAIL rand_resync_exit got=%0d exp=1", state); end
    end else begin
      enable = 1'b0; tick();
      enable = 1'b1; tick();
    end
  endtask

  task automatic test_random_windows();
    int eu, sb, u;
    for (int k = 0; k < 3; k++) begin
      u = $urandom_range(5, 85);
      measure_window(u, $urandom_range(0, 40), eu, sb);
      total++;
      if ({sb == 1, state, ui_len, thr_t1, thr_t2, thr_t3} !==
          {1'b1, 3'd2, 8'(eu), 8'(mdl_t1(eu)), 8'(mdl_t2(eu)), 8'(mdl_t3(eu))}) begin
        bad++;
        $display("FAIL rand_window u=%0d got sb=%0d st=%0d ui=%0d t=%0d/%0d/%0d exp ui=%0d t=%0d/%0d/%0d",
                 u, sb, state, ui_len, thr_t1, thr_t2, thr_t3, eu, mdl_t1(eu), mdl_t2(eu), mdl_t3(eu));
      end
      send_sync(2'd3);
      total++;
      if ({state, err_pulse} !== {3'd1, 1'b1}) begin
        bad++; $display("FAIL inv_first_sync got st=%0d ep=%b exp st=1 ep=1", state, err_pulse);
      end
    end
  endtask

  task automatic test_timeout();
    int eu, sb, pulses, cyc;
    bit found;
    logic [31:0] held;
    measure_window($urandom_range(5, 85), 0, eu, sb);
    held = {thr_t1, thr_t2, thr_t3, ui_len};
    send_lock_seq();
    send_sync(2'd0);
    total++;
    if ({state, mute} !== {3'd3, 1'b0}) begin
      bad++; $display("FAIL to_prelock got st=%0d mu=%b exp st=3 mu=0", state, mute);
    end
    pulses = 0; cyc = 0; found = 1'b0;
    for (int i = 1; i <= STO * EMAX + 200; i++) begin
      tick();
      if (err_pulse === 1'b1) begin
        pulses++;
        total++;
        if (i != STO * pulses) begin bad++; $display("FAIL to_spacing got=%0d exp=%0d", i, STO * pulses); end
      end
      if (state === 3'd4) begin found = 1'b1; cyc = i; break; end
    end
    total++;
    if (!found || cyc != STO * EMAX || pulses != EMAX) begin
      bad++; $display("FAIL to_resync got found=%b cyc=%0d pulses=%0d exp cyc=%0d pulses=%0d",
                      found, cyc, pulses, STO * EMAX, EMAX);
    end
    total++;
    if ({audio_locked, mute} !== 2'b01) begin
      bad++; $display("FAIL to_resync_out got lk=%b mu=%b exp lk=0 mu=1", audio_locked, mute);
    end
    tick();
    total++;
    if ({state, thr_t1, thr_t2, thr_t3, ui_len} !== {3'd1, held}) begin
      bad++; $display("FAIL to_exit got st=%0d thr=%h exp st=1 thr=%h", state,
                      {thr_t1, thr_t2, thr_t3, ui_len}, held);
    end
  endtask

  task automatic test_saturate_disable();
    int eu, sb;
    measure_window(200, 10, eu, sb);
    total++;
    if ({state, ui_len, thr_t1, thr_t2, thr_t3} !== {3'd2, 8'(eu), 8'd255, 8'd255, 8'd255}) begin
      bad++; $display("FAIL sat200 got st=%0d ui=%0d t=%0d/%0d/%0d exp st=2 ui=%0d t=255/255/255",
                      state, ui_len, thr_t1, thr_t2, thr_t3, eu);
    end
    send_lock_seq();
    enable = 1'b0;
    tick();
    total++;
    if ({state, mute, audio_locked} !== {3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL disable got st=%0d mu=%b lk=%b exp 0/1/0", state, mute, audio_locked);
    end
    enable = 1'b1;
    tick();
    measure_window(110, 0, eu, sb);
    total++;
    if ({ui_len, thr_t1, thr_t2, thr_t3} !== {8'(eu), 8'(mdl_t1(eu)), 8'(mdl_t2(eu)), 8'(mdl_t3(eu))}) begin
      bad++; $display("FAIL sat110 got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", ui_len, thr_t1, thr_t2, thr_t3,
                      eu, mdl_t1(eu), mdl_t2(eu), mdl_t3(eu));
    end
  endtask

  task automatic test_async_reset();
    send_sync(2'd0);
    @(posedge clk);
    #3;
    resetb = 1'b0;
    #1;
    total++;
    if ({state, thr_t1, thr_t2, thr_t3, ui_len, audio_locked, mute, err_pulse} !==
        {3'd0, 8'd20, 8'd38, 8'd42, 8'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got st=%0d t1=%0d t2=%0d t3=%0d ui=%0d lk=%b mu=%b exp 0/20/38/42/0/0/1",
               state, thr_t1, thr_t2, thr_t3, ui_len, audio_locked, mute);
    end
    tick();
    resetb = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_measure();
    test_verify_err();
    test_glitch();
    test_lock();
    test_random_locked();
    test_random_windows();
    test_timeout();
    test_saturate_disable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spdif_lock_ctrl.md
Name: spdif_lock_ctrl

Overview:
Acquisition and lock controller for the S/PDIF receive path. It measures the unit interval (UI) from the edge-interval stream, programs the short/long/preamble classification thresholds used by the biphase-mark decoder, and qualifies lock by checking preamble alternation and timing. It drives audio_locked and the I2S output mute, and sits beside the decoder in the top-level, fed by the decoder's edge and sync strobes.

Parameters:
WIN_EDGES, 64, number of accepted edges per UI-measurement window
MIN_LEN, 4, edge lengths below this are treated as glitches and ignored
VERIFY_SYNCS, 8, consecutive correctly alternating preambles needed to declare lock
SYNC_TO, 2048, clocks without a sync_valid before a timeout error (12-bit counter)
ERR_MAX, 4, accumulated errors in LOCKED that force unlock

Ports:
clk  in  1  system clock
resetb  in  1  asynchronous active-low reset
enable  in  1  controller enable; low forces IDLE
edge_valid  in  1  one-cycle strobe: decoder measured an edge interval
edge_len  in  8  interval length in clocks, valid with edge_valid
sync_valid  in  1  one-cycle strobe: decoder recognised a preamble
sync_type  in  2  00=B, 01=M, 10=W, 11=invalid; valid with sync_valid
thr_t1  out  8  short/long boundary
thr_t2  out  8  long/W-preamble boundary
thr_t3  out  8  preamble boundary
ui_len  out  8  last measured UI in clocks
audio_locked  out  1  lock qualified
mute  out  1  forces I2S data to zero
err_pulse  out  1  one-cycle pulse on every detected error
state  out  3  FSM state, for debug

Behaviour:
- Reset (async, resetb=0): state=IDLE, thr_t1=20, thr_t2=38, thr_t3=42, ui_len=0, audio_locked=0, mute=1, err_pulse=0, all counters 0, min register 255.
- FSM states: IDLE=0, MEASURE=1, VERIFY=2, LOCKED=3, RESYNC=4. Registered, synchronous update. enable=0 in any state -> IDLE next cycle, with mute=1 and audio_locked=0 in that same cycle.
- IDLE: enable=1 -> MEASURE. Clear edge count, set min=255.
- MEASURE: on edge_valid with edge_len>=MIN_LEN: edge count +1, min=min(min,edge_len). Edges below MIN_LEN are ignored and not counted. When the count reaches WIN_EDGES (the update cycle includes that edge):
  - If min=255: restart MEASURE.
  - Otherwise: ui_len=min, thr_t1=UI+(UI>>1), thr_t2=2UI+(UI>>2), thr_t3=2UI+(UI>>1). Each threshold is computed in 10 bits and saturates at 255. Then go to VERIFY.
  - Thresholds change only in this cycle.
- Alternation rule: B or M must be followed by W; W must be followed by B or M. The first sync in VERIFY is accepted unconditionally. sync_type=11 is always an error.
- Sync timeout counter: clears on every sync_valid and on entry to VERIFY or LOCKED; increments otherwise. Reaching SYNC_TO is a timeout error, and the counter then clears.
- VERIFY: each good sync increments the good count. Any error (bad alternation, invalid type, timeout) -> err_pulse, go to MEASURE. Good count reaching VERIFY_SYNCS -> LOCKED, audio_locked=1 on entry, mute stays 1.
- LOCKED:
  - mute deasserts on the cycle after the first B sync seen in LOCKED (frame-aligned unmute).
  - Each error pulses err_pulse and increments the error count; a correct W following a correct B/M clears it.
  - Error count reaching ERR_MAX -> RESYNC.
- RESYNC: lasts one cycle. audio_locked=0 and mute=1 take effect in the same cycle as entry; then -> MEASURE. Thresholds hold their old values until re-measured.
- Simultaneous edge_valid and sync_valid: both are processed in the same cycle. Simultaneous good sync and timeout: the sync wins, no error.
- err_pulse is combinational from the registered error decision and is high for exactly one cycle per error.
- Reset mid-operation returns all outputs to reset values immediately (asynchronous).

Decomposition:
- Shared package spdif_pkg: state encodings, sync_type codes (SYNC_B/M/W/INV), default thresholds 20/38/42.
- One natural sub-module, spdif_ui_meter: windowed minimum tracker plus threshold computation. It takes edge_valid/edge_len/start and returns done, ui, and t1/t2/t3.

Test Plan:
- UI=14: 64 edges of lengths 14/28/42 -> ui_len=14, thr_t1=21, thr_t2=31, thr_t3=35, state=VERIFY.
- Window containing edge_len=2 glitches with real UI=14 -> glitches ignored, ui_len=14, and the window needs 64 non-glitch edges.
- After measure, 8 syncs B,W,M,W,M,W,M,W -> audio_locked=1 on the 8th; mute stays 1 until the next B, then mute=0 one cycle later.
- In VERIFY, sequence B,W,W -> err_pulse on the third sync, state=MEASURE, audio_locked=0.
- LOCKED, sync_valid withheld for 4×2048 clocks -> 4 err_pulses, then RESYNC for 1 cycle, mute=1, then MEASURE.
- UI=200 -> thresholds saturate at 255; and enable dropped while LOCKED -> IDLE, mute=1, audio_locked=0 next cycle.
